// File: rtl/acq_sequencer_if.sv
// Command/status bundle around acq_sequencer.
// slave = the sequencer; master = register block / chip-side logic that drives and observes it.
`timescale 1ns/1ps
interface acq_sequencer_if #(
    parameter int EVENT_CNT_WIDTH = 16
);
    logic                       start;
    logic                       abort;
    logic                       clear_err;
    logic [EVENT_CNT_WIDTH-1:0] n_events;
    logic                       fifo_space_ok;
    logic                       trig_from_chip;
    logic                       spi_cmd_ack;
    logic                       AD9228_read_en;
    logic                       trig_to_chip;
    logic                       spi_cmd_req;
    logic                       readout_start;
    logic                       busy;
    logic                       done;
    logic                       error;
    logic [1:0]                 err_code;
    logic [EVENT_CNT_WIDTH-1:0] event_count;

    modport slave (
        input  start, abort, clear_err, n_events, fifo_space_ok,
               trig_from_chip, spi_cmd_ack, AD9228_read_en,
        output trig_to_chip, spi_cmd_req, readout_start, busy, done,
               error, err_code, event_count
    );

    modport master (
        output start, abort, clear_err, n_events, fifo_space_ok,
               trig_from_chip, spi_cmd_ack, AD9228_read_en,
        input  trig_to_chip, spi_cmd_req, readout_start, busy, done,
               error, err_code, event_count
    );
endinterface

// File: rtl/acq_sequencer.sv
// Autonomous trigger / SPI readout-command / ADC readout loop, repeated for a programmed
// number of events, with wait timeouts, sample-count checking and sticky error reporting.
`timescale 1ns/1ps
module acq_sequencer #(
    parameter int NUM_DATA          = 1280,
    parameter int TRIG_PULSE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES    = 40000,
    parameter int GAP_CYCLES        = 16,
    parameter int EVENT_CNT_WIDTH   = 16
) (
    input  logic           clk,
    input  logic           rstn,
    acq_sequencer_if.slave bus
);
    localparam int SMP_W    = $clog2(NUM_DATA) + 1;
    localparam int TMR_MAX0 = (TIMEOUT_CYCLES > TRIG_PULSE_CYCLES) ? TIMEOUT_CYCLES : TRIG_PULSE_CYCLES;
    localparam int TMR_MAX  = (TMR_MAX0 > GAP_CYCLES) ? TMR_MAX0 : GAP_CYCLES;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIG_PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [SMP_W-1:0] SMP_GOOD  = SMP_W'(NUM_DATA);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_SPACE, S_TRIG, S_WAIT_CHIP, S_SPI_CMD,
        S_START_READ, S_WAIT_READ, S_READOUT, S_GAP, S_ERROR
    } state_e;

    state_e                     state_q, state_d;
    logic [TMR_W-1:0]           tmr_q, tmr_d;
    logic [SMP_W-1:0]           smp_q, smp_d;
    logic [EVENT_CNT_WIDTH-1:0] evt_q, evt_d;
    logic [EVENT_CNT_WIDTH-1:0] nlat_q, nlat_d;
    logic [1:0]                 err_q, err_d;
    logic                       done_q, done_d;
    logic [2:0]                 sync_q;
    logic                       trig_q, req_q, rs_q, busy_q, error_q;
    logic                       chip_edge;

    // sync_q[1:0] is the two-flop synchronizer; sync_q[2] holds the previous synced level.
    assign chip_edge = sync_q[1] & ~sync_q[2];

    always_comb begin
        // NOTE: every next-state variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d = state_q;
        smp_d   = smp_q;
        evt_d   = evt_q;
        nlat_d  = nlat_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    nlat_d  = bus.n_events;
                    evt_d   = '0;
                    state_d = S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: if (bus.fifo_space_ok) state_d = S_TRIG;
            S_TRIG:       if (tmr_q == TRIG_LAST) state_d = S_WAIT_CHIP;
            S_WAIT_CHIP: begin
                if (chip_edge) begin
                    state_d = S_SPI_CMD;
                end else if (tmr_q == TO_LAST) begin
                    state_d = S_ERROR;
                    err_d   = 2'd1;
                end
            end
            S_SPI_CMD:    if (bus.spi_cmd_ack) state_d = S_START_READ;
            S_START_READ: state_d = S_WAIT_READ;
            S_WAIT_READ: begin
                if (bus.AD9228_read_en) begin
                    state_d = S_READOUT;
                    smp_d   = SMP_W'(1);
                end else if (tmr_q == TO_LAST) begin
                    state_d = S_ERROR;
                    err_d   = 2'd2;
                end
            end
            S_READOUT: begin
                if (bus.AD9228_read_en) begin
                    // Saturate so an overlong readout can never wrap back onto the good count.
                    smp_d = (&smp_q) ? smp_q : smp_q + SMP_W'(1);
                end else if (smp_q == SMP_GOOD) begin
                    evt_d   = evt_q + EVENT_CNT_WIDTH'(1);
                    state_d = S_GAP;
                end else begin
                    state_d = S_ERROR;
                    err_d   = 2'd3;
                end
            end
            S_GAP: begin
                if (tmr_q == GAP_LAST) begin
                    if ((nlat_q != '0) && (evt_q == nlat_q)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_SPACE;
                    end
                end
            end
            S_ERROR: begin
                if (bus.clear_err) begin
                    state_d = S_IDLE;
                    err_d   = 2'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort outranks every transition above, including a same-cycle ack, timeout or event completion.
        if (bus.abort && (state_q != S_IDLE) && (state_q != S_ERROR)) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            evt_d   = evt_q;
            err_d   = err_q;
        end
    end

    // The shared timer restarts on every state change, so each wait is measured from its own entry.
    assign tmr_d = (state_d != state_q) ? '0 : tmr_q + TMR_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            smp_q   <= '0;
            evt_q   <= '0;
            nlat_q  <= '0;
            err_q   <= 2'd0;
            done_q  <= 1'b0;
            sync_q  <= '0;
            trig_q  <= 1'b0;
            req_q   <= 1'b0;
            rs_q    <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            tmr_q   <= tmr_d;
            smp_q   <= smp_d;
            evt_q   <= evt_d;
            nlat_q  <= nlat_d;
            err_q   <= err_d;
            done_q  <= done_d;
            sync_q  <= {sync_q[1:0], bus.trig_from_chip};
            // Outputs are decoded from the next state into flops: glitch-free, same timing as the state.
            trig_q  <= (state_d == S_TRIG);
            req_q   <= (state_d == S_SPI_CMD);
            rs_q    <= (state_d == S_START_READ);
            busy_q  <= (state_d != S_IDLE) && (state_d != S_ERROR);
            error_q <= (state_d == S_ERROR);
        end
    end

    assign bus.trig_to_chip  = trig_q;
    assign bus.spi_cmd_req   = req_q;
    assign bus.readout_start = rs_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.error         = error_q;
    assign bus.err_code      = err_q;
    assign bus.event_count   = evt_q;
endmodule
